// File: rtl/interrupt_controller.sv
// Three-source prioritised interrupt controller with edge capture, mask, global enable,
// in-service tracking and a 3-deep EPC stack. All state moves on the falling clock edge.
module interrupt_controller #(
    parameter logic [31:0] VEC1 = 32'h0000_0100,
    parameter logic [31:0] VEC2 = 32'h0000_0200,
    parameter logic [31:0] VEC3 = 32'h0000_0300,
    parameter bit          NEST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq,
    input  logic        mask_we,
    input  logic [2:0]  mask_din,
    input  logic        gie_we,
    input  logic        gie_din,
    input  logic        eret,
    input  logic [31:0] pc_next,
    output logic        int_req,
    output logic [31:0] int_vector,
    output logic [1:0]  int_id,
    output logic [31:0] epc,
    output logic [2:0]  mask,
    output logic        gie,
    output logic [2:0]  isr
);

    logic [2:0]  pending;
    logic [2:0]  irq_prev;
    logic [2:0]  nest_ok;
    logic [2:0]  elig;
    logic [2:0]  win;
    logic [2:0]  clr;
    logic [1:0]  sp;
    logic [31:0] stack [0:2];
    logic        take;
    logic        do_ret;

    always_comb begin
        if (NEST) begin
            nest_ok[2] = ~isr[2];
            nest_ok[1] = ~(|isr[2:1]);
            nest_ok[0] = ~(|isr);
        end else begin
            nest_ok = {3{isr == 3'b000}};
        end
    end

    assign elig = pending & ~mask & {3{gie}} & nest_ok;

    always_comb begin
        win        = 3'b000;
        int_id     = 2'd0;
        int_vector = 32'h0;
        if (elig[2]) begin
            win        = 3'b100;
            int_id     = 2'd1;
            int_vector = VEC1;
        end else if (elig[1]) begin
            win        = 3'b010;
            int_id     = 2'd2;
            int_vector = VEC2;
        end else if (elig[0]) begin
            win        = 3'b001;
            int_id     = 2'd3;
            int_vector = VEC3;
        end
    end

    assign int_req = |elig;
    assign take    = int_req;
    // a return is discarded whenever a take happens on the same edge
    assign do_ret  = eret & ~int_req & (|isr);

    always_comb begin
        clr = 3'b000;
        if (isr[2])      clr = 3'b100;
        else if (isr[1]) clr = 3'b010;
        else if (isr[0]) clr = 3'b001;
    end

    always_comb begin
        case (sp)
            2'd1:    epc = stack[0];
            2'd2:    epc = stack[1];
            2'd3:    epc = stack[2];
            default: epc = 32'h0;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 3'b000;
            irq_prev <= 3'b111;
            isr      <= 3'b000;
            mask     <= 3'b000;
            gie      <= 1'b1;
            sp       <= 2'd0;
            for (int i = 0; i < 3; i++) stack[i] <= 32'h0;
        end else begin
            irq_prev <= irq;
            // a fresh edge on the winning line in the take cycle survives the clear
            pending  <= (pending & ~win) | (irq & ~irq_prev);
            if (mask_we) mask <= mask_din;
            if (gie_we)  gie  <= gie_din;
            if (take) begin
                isr <= isr | win;
                sp  <= sp + 2'd1;
                for (int i = 0; i < 3; i++) begin
                    if (sp == 2'(i)) stack[i] <= pc_next;
                end
            end else if (do_ret) begin
                isr <= isr & ~clr;
                sp  <= sp - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; inputs change just after the
// falling edge, combinational outputs are checked mid-cycle, registered ones after the edge.
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic [2:0]  irq;
    logic        mask_we;
    logic [2:0]  mask_din;
    logic        gie_we;
    logic        gie_din;
    logic        eret;
    logic [31:0] pc_next;
    logic        int_req;
    logic [31:0] int_vector;
    logic [1:0]  int_id;
    logic [31:0] epc;
    logic [2:0]  mask;
    logic        gie;
    logic [2:0]  isr;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_din(mask_din),
        .gie_we(gie_we), .gie_din(gie_din), .eret(eret), .pc_next(pc_next),
        .int_req(int_req), .int_vector(int_vector), .int_id(int_id), .epc(epc),
        .mask(mask), .gie(gie), .isr(isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse(input logic [2:0] v);
        irq = v;
        tick();
        irq = 3'b000;
        #1;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = 3'b000; mask_we = 0; mask_din = 0; gie_we = 0; gie_din = 0;
        eret = 0; pc_next = 32'h0;
        #3;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", int_req); end
        checks++; if (isr !== 3'b000) begin errors++; $display("FAIL rst_isr got %b exp 000", isr); end
        checks++; if (mask !== 3'b000) begin errors++; $display("FAIL rst_mask got %b exp 000", mask); end
        checks++; if (gie !== 1'b1) begin errors++; $display("FAIL rst_gie got %0b exp 1", gie); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", epc); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        pc_next = 32'h1000;
        pulse(3'b001);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL t1_req got %0b exp 1", int_req); end
        checks++; if (int_vector !== 32'h300) begin errors++; $display("FAIL t1_vec got %h exp 300", int_vector); end
        checks++; if (int_id !== 2'd3) begin errors++; $display("FAIL t1_id got %0d exp 3", int_id); end
        tick();
        checks++; if (isr !== 3'b001) begin errors++; $display("FAIL t1_isr got %b exp 001", isr); end
        checks++; if (epc !== 32'h1000) begin errors++; $display("FAIL t1_epc got %h exp 1000", epc); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t1_req_once got %0b exp 0", int_req); end
        checks++; if (int_id !== 2'd0 || int_vector !== 32'h0) begin errors++; $display("FAIL t1_idle_out got id=%0d vec=%h exp 0/0", int_id, int_vector); end
        do_eret();
        checks++; if (isr !== 3'b000 || epc !== 32'h0) begin errors++; $display("FAIL t1_ret got isr=%b epc=%h exp 000/0", isr, epc); end
    endtask

    task automatic test_nesting();
        pc_next = 32'h1000;
        pulse(3'b001);
        tick();
        pc_next = 32'h2000;
        pulse(3'b100);
        checks++; if (int_req !== 1'b1 || int_vector !== 32'h100 || int_id !== 2'd1) begin
            errors++; $display("FAIL t2_pre got req=%0b vec=%h id=%0d exp 1/100/1", int_req, int_vector, int_id); end
        tick();
        checks++; if (isr !== 3'b101) begin errors++; $display("FAIL t2_isr got %b exp 101", isr); end
        checks++; if (epc !== 32'h2000) begin errors++; $display("FAIL t2_epc got %h exp 2000", epc); end
        do_eret();
        checks++; if (isr !== 3'b001 || epc !== 32'h1000) begin errors++; $display("FAIL t2_ret1 got isr=%b epc=%h exp 001/1000", isr, epc); end
        do_eret();
        checks++; if (isr !== 3'b000 || epc !== 32'h0) begin errors++; $display("FAIL t2_ret2 got isr=%b epc=%h exp 000/0", isr, epc); end
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_din = 3'b010;
        tick();
        mask_we = 1'b0;
        checks++; if (mask !== 3'b010) begin errors++; $display("FAIL t3_mask got %b exp 010", mask); end
        pulse(3'b010);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t3_blocked got %0b exp 0", int_req); end
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t3_blocked2 got %0b exp 0", int_req); end
        mask_we = 1'b1; mask_din = 3'b000;
        #1;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t3_write_cycle got %0b exp 0", int_req); end
        tick();
        mask_we = 1'b0;
        #1;
        checks++; if (int_req !== 1'b1 || int_vector !== 32'h200) begin errors++; $display("FAIL t3_retained got req=%0b vec=%h exp 1/200", int_req, int_vector); end
        tick();
        checks++; if (isr !== 3'b010) begin errors++; $display("FAIL t3_isr got %b exp 010", isr); end
        do_eret();
    endtask

    task automatic test_priority();
        pc_next = 32'h3000;
        pulse(3'b101);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd1 || int_vector !== 32'h100) begin
            errors++; $display("FAIL t4_first got req=%0b id=%0d vec=%h exp 1/1/100", int_req, int_id, int_vector); end
        tick();
        checks++; if (isr !== 3'b100) begin errors++; $display("FAIL t4_isr got %b exp 100", isr); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t4_blocked got %0b exp 0", int_req); end
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t4_blocked2 got %0b exp 0", int_req); end
        do_eret();
        checks++; if (int_req !== 1'b1 || int_vector !== 32'h300) begin errors++; $display("FAIL t4_second got req=%0b vec=%h exp 1/300", int_req, int_vector); end
        tick();
        checks++; if (isr !== 3'b001) begin errors++; $display("FAIL t4_isr2 got %b exp 001", isr); end
        do_eret();
    endtask

    task automatic test_back_to_back();
        int takes;
        takes = 0;
        irq = 3'b010;
        tick();
        #1;
        for (int i = 0; i < 6; i++) begin
            if (int_req) takes++;
            if (i == 2) eret = 1'b1;
            tick();
            eret = 1'b0;
            #1;
        end
        irq = 3'b000;
        checks++; if (takes !== 1) begin errors++; $display("FAIL t5_level got %0d takes exp 1", takes); end
        checks++; if (isr !== 3'b000) begin errors++; $display("FAIL t5_level_isr got %b exp 000", isr); end
        do_eret();
        checks++; if (isr !== 3'b000 || epc !== 32'h0 || int_req !== 1'b0) begin
            errors++; $display("FAIL t5_stray got isr=%b epc=%h req=%0b exp 000/0/0", isr, epc, int_req); end
        pc_next = 32'h5000;
        pulse(3'b001);
        tick();
        pc_next = 32'h5100;
        pulse(3'b100);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++; if (isr !== 3'b101 || epc !== 32'h5100) begin
            errors++; $display("FAIL t5_take_wins got isr=%b epc=%h exp 101/5100", isr, epc); end
        do_eret();
        checks++; if (epc !== 32'h5000) begin errors++; $display("FAIL t5_epc got %h exp 5000", epc); end
        do_eret();
    endtask

    task automatic test_gie();
        pc_next = 32'h4000;
        pulse(3'b001);
        gie_we = 1'b1; gie_din = 1'b0;
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL t7_req got %0b exp 1", int_req); end
        tick();
        gie_we = 1'b0;
        checks++; if (isr !== 3'b001 || gie !== 1'b0) begin errors++; $display("FAIL t7_take got isr=%b gie=%0b exp 001/0", isr, gie); end
        do_eret();
        pulse(3'b010);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t7_gie_off got %0b exp 0", int_req); end
        gie_we = 1'b1; gie_din = 1'b1;
        tick();
        gie_we = 1'b0;
        #1;
        checks++; if (int_req !== 1'b1 || int_id !== 2'd2) begin errors++; $display("FAIL t7_gie_on got req=%0b id=%0d exp 1/2", int_req, int_id); end
        tick();
        do_eret();
    endtask

    task automatic test_reset_mid();
        pc_next = 32'h6000;
        pulse(3'b001);
        tick();
        pc_next = 32'h7000;
        pulse(3'b100);
        tick();
        mask_we = 1'b1; mask_din = 3'b010; gie_we = 1'b1; gie_din = 1'b0;
        tick();
        mask_we = 1'b0; gie_we = 1'b0;
        checks++; if (isr !== 3'b101 || epc !== 32'h7000) begin errors++; $display("FAIL t6_setup got isr=%b epc=%h exp 101/7000", isr, epc); end
        #2;
        irq = 3'b111;
        rst = 1'b1;
        #1;
        checks++; if (isr !== 3'b000 || epc !== 32'h0 || int_req !== 1'b0) begin
            errors++; $display("FAIL t6_async got isr=%b epc=%h req=%0b exp 000/0/0", isr, epc, int_req); end
        checks++; if (mask !== 3'b000 || gie !== 1'b1) begin errors++; $display("FAIL t6_regs got mask=%b gie=%0b exp 000/1", mask, gie); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (int_req !== 1'b0 || isr !== 3'b000) begin errors++; $display("FAIL t6_held got req=%0b isr=%b exp 0/000", int_req, isr); end
        irq = 3'b000;
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL t6_after got %0b exp 0", int_req); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nesting();
        test_mask();
        test_priority();
        test_back_to_back();
        test_gie();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
